// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing generator.
//   - default 800x600@60 Hz mode constants (40 MHz pixel clock)
//   - per-axis phase enumeration
//   - counter width and the largest total it can hold
package vga_timing_pkg;

    localparam int CNT_W       = 12;
    localparam int CNT_MAX_TOT = 1 << CNT_W;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;

    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): count register plus phase FSM.
//
// state     | meaning
// ----------+---------------------------------------------
// PH_ACTIVE | visible region, blank low, sync inactive
// PH_FP     | front porch, blank high, sync inactive
// PH_SYNC   | sync pulse, blank high, sync at POL level
// PH_BP     | back porch, blank high, sync inactive
//
// Ports:
//   pclk, rst  pixel clock, synchronous active-high reset
//   advance    step the count this cycle (1 for H, H wrap for V)
//   count      registered position, 0..TOT-1
//   wrap       combinational: this advance takes count from TOT-1 to 0
//   blank      registered, high outside PH_ACTIVE
//   sync       registered, POL while in PH_SYNC, ~POL otherwise
// blank/sync are derived from the next count/state so they are always
// aligned with count in the same cycle.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = 1'b1
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             blank,
    output logic             sync
);

    localparam int TOT = ACTIVE + FP + SYNC + BP;

    if (TOT > CNT_MAX_TOT) begin : g_tot_check
        $error("vga_axis_counter: total %0d does not fit the counter", TOT);
    end
    if (ACTIVE < 1) begin : g_active_check
        $error("vga_axis_counter: active region must be non-empty");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOT - 1);

    // Count value at which each phase ends (first count of the following
    // phase); modulo TOT so trailing zero-length phases land on 0.
    localparam logic [CNT_W-1:0] END_ACTIVE = CNT_W'(ACTIVE % TOT);
    localparam logic [CNT_W-1:0] END_FP     = CNT_W'((ACTIVE + FP) % TOT);
    localparam logic [CNT_W-1:0] END_SYNC   = CNT_W'((ACTIVE + FP + SYNC) % TOT);

    // Successor of each phase with zero-length phases skipped.
    localparam phase_t AFTER_ACTIVE = (FP > 0)   ? PH_FP   :
                                      (SYNC > 0) ? PH_SYNC :
                                      (BP > 0)   ? PH_BP   : PH_ACTIVE;
    localparam phase_t AFTER_FP     = (SYNC > 0) ? PH_SYNC :
                                      (BP > 0)   ? PH_BP   : PH_ACTIVE;
    localparam phase_t AFTER_SYNC   = (BP > 0)   ? PH_BP   : PH_ACTIVE;

    phase_t           state;
    phase_t           state_next;
    logic [CNT_W-1:0] count_next;

    assign wrap = advance && (count == LAST);

    always_comb begin
        count_next = count;
        state_next = state;
        if (advance) begin
            count_next = wrap ? '0 : count + 1'b1;
            case (state)
                PH_ACTIVE: if (count_next == END_ACTIVE) state_next = AFTER_ACTIVE;
                PH_FP:     if (count_next == END_FP)     state_next = AFTER_FP;
                PH_SYNC:   if (count_next == END_SYNC)   state_next = AFTER_SYNC;
                PH_BP:     if (count_next == '0)         state_next = PH_ACTIVE;
                default:   state_next = PH_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            count <= '0;
            state <= PH_ACTIVE;
            blank <= 1'b0;
            sync  <= ~POL;
        end else begin
            count <= count_next;
            state <= state_next;
            blank <= (state_next != PH_ACTIVE);
            sync  <= (state_next == PH_SYNC) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing source at the head of the video pipeline.
// Produces registered, mutually aligned horizontal/vertical counts, sync,
// blanking and line/frame start pulses for a parameterised mode
// (default 800x600@60 Hz, 40 MHz pclk).
//
// Ports:
//   pclk, rst                 pixel clock, synchronous active-high reset
//   hcount_out/vcount_out     pixel and line index
//   hsync_out/vsync_out       syncs, polarity set by HSYNC_POL/VSYNC_POL
//   hblnk_out/vblnk_out       high outside the visible area
//   line_start                high while hcount_out == 0 (not during reset)
//   frame_start               high while hcount_out == 0 and vcount_out == 0
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic             pclk,
    input  logic             rst,
    output logic [CNT_W-1:0] hcount_out,
    output logic             hsync_out,
    output logic             hblnk_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             vsync_out,
    output logic             vblnk_out,
    output logic             line_start,
    output logic             frame_start
);

    logic h_wrap;
    logic v_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HSYNC_POL)
    ) u_h_axis (
        .pclk    (pclk),
        .rst     (rst),
        .advance (1'b1),
        .count   (hcount_out),
        .wrap    (h_wrap),
        .blank   (hblnk_out),
        .sync    (hsync_out)
    );

    // The vertical axis steps only on the H wrap, so its outputs change
    // on the same edge hcount returns to 0.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VSYNC_POL)
    ) u_v_axis (
        .pclk    (pclk),
        .rst     (rst),
        .advance (h_wrap),
        .count   (vcount_out),
        .wrap    (v_wrap),
        .blank   (vblnk_out),
        .sync    (vsync_out)
    );

    // v_wrap already includes h_wrap, so it marks the next (0,0) position.
    always_ff @(posedge pclk) begin
        if (rst) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using two reduced modes so whole frames fit in a
// short run:
//   A: H 8/2/3/2 (tot 15), V 4/1/2/1 (tot 8), syncs active-high, frame 120
//   B: H 6/0/2/2 (tot 10), V 3/1/1/0 (tot 5), syncs active-low, zero-length
//      H front porch and V back porch
module tb_vga_timing_gen;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;

    logic [11:0] a_hc, a_vc, b_hc, b_vc;
    logic        a_hs, a_hb, a_vs, a_vb, a_ls, a_fs;
    logic        b_hs, b_hb, b_vs, b_vb, b_ls, b_fs;

    int n_checks = 0;
    int n_fail   = 0;
    int ha, va, hb, vb;

    always #5 pclk = ~pclk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_a (
        .pclk(pclk), .rst(rst),
        .hcount_out(a_hc), .hsync_out(a_hs), .hblnk_out(a_hb),
        .vcount_out(a_vc), .vsync_out(a_vs), .vblnk_out(a_vb),
        .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(6), .H_FP(0), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(0),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut_b (
        .pclk(pclk), .rst(rst),
        .hcount_out(b_hc), .hsync_out(b_hs), .hblnk_out(b_hb),
        .vcount_out(b_vc), .vsync_out(b_vs), .vblnk_out(b_vb),
        .line_start(b_ls), .frame_start(b_fs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (model A h=%0d v=%0d, B h=%0d v=%0d)",
                   tag, obs, exp, ha, va, hb, vb);
        end
    endtask

    // Advance both reference positions by one pixel clock.
    task automatic step_model();
        if (ha == 14) begin
            ha = 0;
            va = (va == 7) ? 0 : va + 1;
        end else begin
            ha = ha + 1;
        end
        if (hb == 9) begin
            hb = 0;
            vb = (vb == 4) ? 0 : vb + 1;
        end else begin
            hb = hb + 1;
        end
    endtask

    task automatic check_all();
        chk("a_hcount", a_hc, ha);
        chk("a_vcount", a_vc, va);
        chk("a_hblnk",  a_hb, ha >= 8);
        chk("a_hsync",  a_hs, ha >= 10 && ha <= 12);
        chk("a_vblnk",  a_vb, va >= 4);
        chk("a_vsync",  a_vs, va >= 5 && va <= 6);
        chk("a_line_start",  a_ls, ha == 0);
        chk("a_frame_start", a_fs, ha == 0 && va == 0);
        chk("b_hcount", b_hc, hb);
        chk("b_vcount", b_vc, vb);
        chk("b_hblnk",  b_hb, hb >= 6);
        chk("b_hsync",  b_hs, !(hb >= 6 && hb <= 7));
        chk("b_vblnk",  b_vb, vb >= 3);
        chk("b_vsync",  b_vs, vb != 4);
        chk("b_line_start",  b_ls, hb == 0);
        chk("b_frame_start", b_fs, hb == 0 && vb == 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_a_hcount"}, a_hc, 0);
        chk({tag, "_a_vcount"}, a_vc, 0);
        chk({tag, "_a_hblnk"},  a_hb, 0);
        chk({tag, "_a_vblnk"},  a_vb, 0);
        chk({tag, "_a_hsync"},  a_hs, 0);
        chk({tag, "_a_vsync"},  a_vs, 0);
        chk({tag, "_a_ls"},     a_ls, 0);
        chk({tag, "_a_fs"},     a_fs, 0);
        chk({tag, "_b_hcount"}, b_hc, 0);
        chk({tag, "_b_vcount"}, b_vc, 0);
        chk({tag, "_b_hsync"},  b_hs, 1);
        chk({tag, "_b_vsync"},  b_vs, 1);
        chk({tag, "_b_hblnk"},  b_hb, 0);
        chk({tag, "_b_vblnk"},  b_vb, 0);
    endtask

    initial begin
        int last_fs;
        int n_ls;
        int n_fs;
        int first_fs;
        int reached;

        ha = 0; va = 0; hb = 0; vb = 0;

        // Reset held for three edges.
        rst = 1'b1;
        repeat (3) @(negedge pclk);
        check_reset("reset");

        // Release: counting starts at 1 on the first free edge.
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge pclk);
            step_model();
            chk("post_release_hcount", a_hc, i);
            chk("post_release_vcount", a_vc, 0);
            check_all();
        end

        // Free run across more than two frames of mode A.
        last_fs = -1;
        n_ls    = 0;
        n_fs    = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge pclk);
            step_model();
            check_all();
            if (a_fs) begin
                if (last_fs >= 0) begin
                    chk("frame_period", c - last_fs, 120);
                    chk("lines_per_frame", n_ls, 8);
                end
                last_fs = c;
                n_ls    = 0;
                n_fs++;
            end
            if (a_ls) n_ls++;
        end
        chk("frame_starts_seen", n_fs >= 2, 1);

        // Run to A at h=5, v=3 then reset mid-frame.
        reached = 0;
        for (int c = 0; c < 200 && !reached; c++) begin
            @(negedge pclk);
            step_model();
            check_all();
            if (ha == 5 && va == 3) reached = 1;
        end
        chk("reached_mid_frame", reached, 1);
        chk("mid_frame_hcount", a_hc, 5);
        chk("mid_frame_vcount", a_vc, 3);

        rst = 1'b1;
        @(negedge pclk);
        ha = 0; va = 0; hb = 0; vb = 0;
        check_reset("mid_reset");
        rst = 1'b0;

        // The reset cycle holds count 0; frame_start must follow one full
        // frame (120 edges) later.
        first_fs = -1;
        for (int c = 1; c <= 130; c++) begin
            @(negedge pclk);
            step_model();
            check_all();
            if (a_fs && first_fs < 0) first_fs = c;
        end
        chk("frame_start_after_reset", first_fs, 120);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Source of the VGA timing bus (hcount/hsync/hblnk, vcount/vsync/vblnk) that every downstream pipeline stage consumes and re-registers. Generates horizontal and vertical counters, sync and blanking for a parameterised mode; the default is 800x600@60 Hz with a 40 MHz pclk. Sits at the head of the video pipeline, ahead of the background, character and overlay stages. Every output is registered and mutually consistent in the same cycle.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- HSYNC_POL, 1, 1 = hsync active-high, 0 = active-low
- VSYNC_POL, 1, 1 = vsync active-high, 0 = active-low
- pclk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-high
- hcount_out  out  12  pixel index in line, 0..H_TOT-1
- hsync_out  out  1  horizontal sync, polarity per HSYNC_POL
- hblnk_out  out  1  high when hcount_out >= H_ACTIVE
- vcount_out  out  12  line index in frame, 0..V_TOT-1
- vsync_out  out  1  vertical sync, polarity per VSYNC_POL
- vblnk_out  out  1  high when vcount_out >= V_ACTIVE
- line_start  out  1  one-cycle pulse while hcount_out == 0
- frame_start  out  1  one-cycle pulse while hcount_out == 0 and vcount_out == 0

## Operation
- H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056). V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628). Both must be <= 4096; elaboration fails otherwise.
- Horizontal counter increments every pclk. At H_TOT-1 it wraps to 0.
- Vertical counter increments only on the cycle the horizontal counter wraps. At V_TOT-1, coincident with an H wrap, it wraps to 0.
- hsync is asserted (active level) for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. Defaults: 840..967.
- vsync is asserted for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. Defaults: 601..604. vsync is line-aligned: it changes on the cycle vcount changes, at hcount 0.
- Per-axis phase FSM: ACTIVE -> FP -> SYNC -> BP -> ACTIVE.
  - Transitions happen at the phase boundaries listed above.
  - Blank is high in every phase except ACTIVE. Sync is at its active level only in SYNC.
  - A phase of length 0 is skipped.
- Sync/blank/pulse outputs are computed from the next count values and registered together with the counts. There is no lag between any count output and its flags.

## Timing
- Reset (rst high at a pclk edge): hcount_out = 0, vcount_out = 0, hblnk_out = 0, vblnk_out = 0. hsync_out = !HSYNC_POL, vsync_out = !VSYNC_POL (inactive level). line_start = 0, frame_start = 0. Both FSMs go to ACTIVE.
- First edge with rst low: hcount_out = 1, vcount_out = 0. The first frame_start occurs at the next full frame wrap.
- rst asserted mid-frame: the reset values above apply at the next edge; counting restarts from 0 with no partial-line completion.
- Output latency: 0 cycles between a count output and its flags.
- Line period: H_TOT cycles. Frame period: H_TOT*V_TOT cycles (663168 at defaults).
- Simultaneous H and V wrap: hcount_out = 0, vcount_out = 0, line_start = 1 and frame_start = 1, all in the same cycle.

## Structure
- Package vga_timing_pkg holds:
  - default mode constants (H_*/V_* above)
  - phase enumeration typedef {ACTIVE, FP, SYNC, BP}
  - count width constant (12)
- One sub-module, vga_axis_counter, instantiated twice (horizontal, vertical). Each instance contains:
  - count register and phase FSM
  - parameters ACTIVE/FP/SYNC/BP/POL
  - an advance input (1 for horizontal, H wrap for vertical)
  - wrap, blank and sync outputs
- The top level wires the instances and registers the line_start and frame_start pulses.

## Test plan
- Reset: hold rst 3 cycles -> all outputs at reset values (syncs inactive). Release -> hcount_out = 1, 2, 3… on successive edges.
- Horizontal boundaries: at hcount 799 -> 800, hblnk rises. hsync is active exactly for hcount 840..967 (128 cycles). At 1055 -> 0, hcount wraps and line_start pulses.
- Vertical boundaries: vblnk rises at vcount 600 (at hcount 0). vsync is active for lines 601..604. vcount wraps 627 -> 0 at the H wrap, with frame_start high for exactly one cycle.
- Frame period: measure frame_start-to-frame_start -> 663168 cycles. Count line_start pulses between them -> 628.
- Reset mid-frame: assert rst at hcount 500, vcount 300 -> next edge gives all reset values. After release, the next frame_start arrives exactly 663168 cycles after the first post-reset count of 0.
- Polarity: HSYNC_POL = 0, VSYNC_POL = 0 -> sync outputs idle high, go low on the same windows, and reset to high.
